// File: rtl/xdma_burst_splitter_pkg.sv
// xdma_pkg: shared types and constants for the xDMA burst splitter.
package xdma_pkg;

    localparam int XdmaPageBytes = 4096;

    typedef struct packed {
        logic [7:0] num_beats;
        logic       is_single;
        logic       is_write_data;
    } xdma_req_w_desc_t;

    typedef enum logic [1:0] {IDLE, CALC, ISSUE, DONE} split_state_e;

endpackage

// File: rtl/xdma_burst_splitter_if.sv
// xdma_burst_splitter_if: transfer request, AW request and W-descriptor handshakes of the splitter.
interface xdma_burst_splitter_if
    import xdma_pkg::*;
#(
    parameter int AddrWidth = 48,
    parameter int LenWidth  = 16
);

    logic [AddrWidth-1:0] xfer_addr_i;
    logic [LenWidth-1:0]  xfer_beats_i;
    logic                 xfer_is_write_i;
    logic                 xfer_valid_i;
    logic                 xfer_ready_o;
    logic [AddrWidth-1:0] aw_addr_o;
    logic [7:0]           aw_len_o;
    logic                 aw_valid_o;
    logic                 aw_ready_i;
    xdma_req_w_desc_t     w_desc_o;
    logic                 w_desc_valid_o;
    logic                 w_desc_ready_i;
    logic                 xfer_done_o;

    modport master (
        input  xfer_addr_i, xfer_beats_i, xfer_is_write_i, xfer_valid_i, aw_ready_i, w_desc_ready_i,
        output xfer_ready_o, aw_addr_o, aw_len_o, aw_valid_o, w_desc_o, w_desc_valid_o, xfer_done_o
    );

    modport slave (
        output xfer_addr_i, xfer_beats_i, xfer_is_write_i, xfer_valid_i, aw_ready_i, w_desc_ready_i,
        input  xfer_ready_o, aw_addr_o, aw_len_o, aw_valid_o, w_desc_o, w_desc_valid_o, xfer_done_o
    );

endinterface

// File: rtl/xdma_burst_len_calc.sv
// xdma_burst_len_calc: beats of the next burst; with XDMA_BURST_SPLIT_4K_EN it is also capped at the 4 KiB page end.
module xdma_burst_len_calc
    import xdma_pkg::*;
#(
    parameter int DataWidth     = 512,
    parameter int LenWidth      = 16,
    parameter int MaxBurstBeats = 64
) (
    input  logic [11:0]         addr_i,
    input  logic [LenWidth-1:0] remaining_i,
    output logic [7:0]          burst_o
);

    logic [LenWidth-1:0] cap;

`ifdef XDMA_BURST_SPLIT_4K_EN
    localparam int OffBits = $clog2(DataWidth / 8);

    // Bytes left in the page range 1..4096, hence 13 bits.
    logic [12:0] bytes_to_4k;
    logic [12:0] beats_to_4k;

    assign bytes_to_4k = 13'(XdmaPageBytes) - {1'b0, addr_i};
    assign beats_to_4k = bytes_to_4k >> OffBits;
    assign cap = (beats_to_4k < 13'(MaxBurstBeats)) ? LenWidth'(beats_to_4k) : LenWidth'(MaxBurstBeats);
`else
    logic unused_addr;

    assign unused_addr = ^addr_i;
    assign cap = LenWidth'(MaxBurstBeats);
`endif

    assign burst_o = (remaining_i < cap) ? remaining_i[7:0] : cap[7:0];

endmodule

// File: rtl/xdma_burst_splitter.sv
// xdma_burst_splitter: splits a write transfer into AXI bursts, one AW request and one W-descriptor each.
// Optional feature: define XDMA_BURST_SPLIT_4K_EN to keep every burst inside one 4 KiB page.
module xdma_burst_splitter
    import xdma_pkg::*;
#(
    parameter int AddrWidth     = 48,
    parameter int DataWidth     = 512,
    parameter int LenWidth      = 16,
    parameter int MaxBurstBeats = 64
) (
    input logic                   clk_i,
    input logic                   rst_i,
    xdma_burst_splitter_if.master bus
);

    localparam int BytesPerBeat = DataWidth / 8;
    localparam int OffBits      = $clog2(BytesPerBeat);

    split_state_e         state_q, state_d;
    logic [AddrWidth-1:0] addr_q;
    logic [LenWidth-1:0]  rem_q, rem_next;
    logic [7:0]           burst_q, burst_calc;
    logic                 is_write_q, aw_sent_q, w_sent_q;
    logic                 aw_done, w_done, issue;
    xdma_req_w_desc_t     desc;

    xdma_burst_len_calc #(
        .DataWidth    (DataWidth),
        .LenWidth     (LenWidth),
        .MaxBurstBeats(MaxBurstBeats)
    ) u_len_calc (
        .addr_i     (addr_q[11:0]),
        .remaining_i(rem_q),
        .burst_o    (burst_calc)
    );

    assign issue    = state_q == ISSUE;
    assign aw_done  = aw_sent_q | bus.aw_ready_i;
    assign w_done   = w_sent_q | bus.w_desc_ready_i;
    assign rem_next = rem_q - LenWidth'(burst_q);

    // Next state: a burst retires once both its AW and W-descriptor handshakes have happened.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.xfer_valid_i) state_d = (bus.xfer_beats_i == '0) ? DONE : CALC;
            CALC:    state_d = ISSUE;
            ISSUE:   if (aw_done && w_done) state_d = (rem_next == '0) ? DONE : CALC;
            default: state_d = IDLE;
        endcase
    end

    // State, transfer progress and per-burst sent flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            burst_q    <= '0;
            is_write_q <= 1'b0;
            aw_sent_q  <= 1'b0;
            w_sent_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.xfer_valid_i) begin
                addr_q     <= bus.xfer_addr_i & ~AddrWidth'(BytesPerBeat - 1);
                rem_q      <= bus.xfer_beats_i;
                is_write_q <= bus.xfer_is_write_i;
            end
            if (state_q == CALC) burst_q <= burst_calc;
            if (issue && aw_done && w_done) begin
                aw_sent_q <= 1'b0;
                w_sent_q  <= 1'b0;
                addr_q    <= addr_q + (AddrWidth'(burst_q) << OffBits);
                rem_q     <= rem_next;
            end else if (issue) begin
                aw_sent_q <= aw_done;
                w_sent_q  <= w_done;
            end
        end
    end

    assign desc = '{num_beats: burst_q, is_single: burst_q == 8'd1, is_write_data: is_write_q};

    assign bus.xfer_ready_o   = state_q == IDLE && !rst_i;
    assign bus.aw_valid_o     = issue && !aw_sent_q;
    assign bus.w_desc_valid_o = issue && !w_sent_q;
    assign bus.aw_addr_o      = issue ? addr_q : '0;
    assign bus.aw_len_o       = issue ? burst_q - 8'd1 : '0;
    assign bus.w_desc_o       = issue ? desc : '0;
    assign bus.xfer_done_o    = state_q == DONE;

endmodule

// File: tb/tb_xdma_burst_splitter.sv
// tb_xdma_burst_splitter: table-driven transfers plus backpressure, zero-length and mid-burst reset sequences.
module tb_xdma_burst_splitter;
    import xdma_pkg::*;

    typedef struct {
        logic [47:0]      addr;
        logic [15:0]      beats;
        logic             wr;
        int               n;
        logic [3:0][47:0] ea;
        logic [3:0][7:0]  el;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    vec_t vecs[6];
    logic [47:0]      aw_addr_q[$];
    logic [7:0]       aw_len_q[$];
    xdma_req_w_desc_t w_q[$];

    xdma_burst_splitter_if bus ();

    xdma_burst_splitter dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Record every completed handshake and done pulse, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (bus.aw_valid_o && bus.aw_ready_i) begin
                aw_addr_q.push_back(bus.aw_addr_o);
                aw_len_q.push_back(bus.aw_len_o);
            end
            if (bus.w_desc_valid_o && bus.w_desc_ready_i) w_q.push_back(bus.w_desc_o);
            if (bus.xfer_done_o) done_cnt++;
        end
    end

    // Hard stop in case a sequence never returns.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [47:0] addr, input logic [15:0] beats, input logic wr,
                           input int n, input logic [47:0] a0, input logic [7:0] l0,
                           input logic [47:0] a1, input logic [7:0] l1, input logic [47:0] a2, input logic [7:0] l2);
        vecs[i].addr  = addr;
        vecs[i].beats = beats;
        vecs[i].wr    = wr;
        vecs[i].n     = n;
        vecs[i].ea    = '{48'h0, a2, a1, a0};
        vecs[i].el    = '{8'h0, l2, l1, l0};
    endtask

    task automatic start_xfer(input logic [47:0] addr, input logic [15:0] beats, input logic wr);
        bus.xfer_addr_i     = addr;
        bus.xfer_beats_i    = beats;
        bus.xfer_is_write_i = wr;
        bus.xfer_valid_i    = 1'b1;
        cyc();
        bus.xfer_valid_i = 1'b0;
    endtask

    task automatic run_vec(input int i);
        int d0;
        aw_addr_q.delete();
        aw_len_q.delete();
        w_q.delete();
        d0 = done_cnt;
        bus.aw_ready_i     = 1'b1;
        bus.w_desc_ready_i = 1'b1;
        start_xfer(vecs[i].addr, vecs[i].beats, vecs[i].wr);
        for (int c = 0; c < 400 && done_cnt == d0; c++) cyc();
        repeat (4) cyc();
        chk($sformatf("v%0d done_pulses", i), 64'(done_cnt - d0), 64'd1);
        chk($sformatf("v%0d aw_count", i), 64'(aw_addr_q.size()), 64'(vecs[i].n));
        chk($sformatf("v%0d w_count", i), 64'(w_q.size()), 64'(vecs[i].n));
        for (int j = 0; j < vecs[i].n; j++) begin
            if (j < aw_addr_q.size()) begin
                chk($sformatf("v%0d b%0d aw_addr", i, j), 64'(aw_addr_q[j]), 64'(vecs[i].ea[j]));
                chk($sformatf("v%0d b%0d aw_len", i, j), 64'(aw_len_q[j]), 64'(vecs[i].el[j]));
            end
            if (j < w_q.size()) begin
                chk($sformatf("v%0d b%0d num_beats", i, j), 64'(w_q[j].num_beats), 64'(vecs[i].el[j]) + 64'd1);
                chk($sformatf("v%0d b%0d is_single", i, j), 64'(w_q[j].is_single), 64'(vecs[i].el[j] == 8'd0));
                chk($sformatf("v%0d b%0d is_write", i, j), 64'(w_q[j].is_write_data), 64'(vecs[i].wr));
            end
        end
    endtask

    // Main sequence: reset, vector table, then hand-written corner cases.
    initial begin
        bus.xfer_addr_i     = '0;
        bus.xfer_beats_i    = '0;
        bus.xfer_is_write_i = 1'b0;
        bus.xfer_valid_i    = 1'b0;
        bus.aw_ready_i      = 1'b0;
        bus.w_desc_ready_i  = 1'b0;

        set_vec(0, 48'h0, 16'd10, 1'b1, 1, 48'h0, 8'd9, 48'h0, 8'd0, 48'h0, 8'd0);
        set_vec(2, 48'h0, 16'd150, 1'b1, 3, 48'h0, 8'd63, 48'h1000, 8'd63, 48'h2000, 8'd21);
`ifdef XDMA_BURST_SPLIT_4K_EN
        set_vec(1, 48'hFC0, 16'd10, 1'b0, 2, 48'hFC0, 8'd0, 48'h1000, 8'd8, 48'h0, 8'd0);
        set_vec(3, 48'h1FA5, 16'd3, 1'b0, 2, 48'h1F80, 8'd1, 48'h2000, 8'd0, 48'h0, 8'd0);
        set_vec(4, 48'hFFFF_FFFF_FFC0, 16'd2, 1'b1, 2, 48'hFFFF_FFFF_FFC0, 8'd0, 48'h0, 8'd0, 48'h0, 8'd0);
        set_vec(5, 48'hA40, 16'd64, 1'b1, 2, 48'hA40, 8'd22, 48'h1000, 8'd40, 48'h0, 8'd0);
`else
        set_vec(1, 48'hFC0, 16'd10, 1'b0, 1, 48'hFC0, 8'd9, 48'h0, 8'd0, 48'h0, 8'd0);
        set_vec(3, 48'h1FA5, 16'd3, 1'b0, 1, 48'h1F80, 8'd2, 48'h0, 8'd0, 48'h0, 8'd0);
        set_vec(4, 48'hFFFF_FFFF_FFC0, 16'd2, 1'b1, 1, 48'hFFFF_FFFF_FFC0, 8'd1, 48'h0, 8'd0, 48'h0, 8'd0);
        set_vec(5, 48'hA40, 16'd64, 1'b1, 1, 48'hA40, 8'd63, 48'h0, 8'd0, 48'h0, 8'd0);
`endif

        repeat (3) cyc();
        chk("rst xfer_ready", 64'(bus.xfer_ready_o), 64'd0);
        chk("rst aw_valid", 64'(bus.aw_valid_o), 64'd0);
        chk("rst w_valid", 64'(bus.w_desc_valid_o), 64'd0);
        chk("rst done", 64'(bus.xfer_done_o), 64'd0);
        chk("rst aw_addr", 64'(bus.aw_addr_o), 64'd0);
        chk("rst aw_len", 64'(bus.aw_len_o), 64'd0);
        chk("rst w_desc", 64'(bus.w_desc_o), 64'd0);
        rst = 1'b0;
        cyc();
        chk("idle xfer_ready", 64'(bus.xfer_ready_o), 64'd1);

        for (int i = 0; i < 6; i++) run_vec(i);

        begin
            int d0;
            d0 = done_cnt;
            bus.aw_ready_i     = 1'b0;
            bus.w_desc_ready_i = 1'b0;
            start_xfer(48'h0, 16'd100, 1'b1);
            chk("bp calc aw_valid", 64'(bus.aw_valid_o), 64'd0);
            chk("bp calc xfer_ready", 64'(bus.xfer_ready_o), 64'd0);
            cyc();
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("bp k%0d aw_valid", k), 64'(bus.aw_valid_o), 64'd1);
                chk($sformatf("bp k%0d w_valid", k), 64'(bus.w_desc_valid_o), 64'(k <= 2));
                chk($sformatf("bp k%0d aw_addr", k), 64'(bus.aw_addr_o), 64'h0);
                chk($sformatf("bp k%0d aw_len", k), 64'(bus.aw_len_o), 64'd63);
                chk($sformatf("bp k%0d num_beats", k), 64'(bus.w_desc_o.num_beats), 64'd64);
                bus.w_desc_ready_i = (k == 2);
                cyc();
            end
            bus.w_desc_ready_i = 1'b0;
            chk("bp held aw_valid", 64'(bus.aw_valid_o), 64'd1);
            chk("bp held w_valid", 64'(bus.w_desc_valid_o), 64'd0);
            bus.aw_ready_i = 1'b1;
            cyc();
            bus.aw_ready_i = 1'b0;
            chk("bp gap aw_valid", 64'(bus.aw_valid_o), 64'd0);
            chk("bp gap w_valid", 64'(bus.w_desc_valid_o), 64'd0);
            cyc();
            chk("bp b2 aw_valid", 64'(bus.aw_valid_o), 64'd1);
            chk("bp b2 w_valid", 64'(bus.w_desc_valid_o), 64'd1);
            chk("bp b2 aw_addr", 64'(bus.aw_addr_o), 64'h1000);
            chk("bp b2 aw_len", 64'(bus.aw_len_o), 64'd35);
            chk("bp b2 num_beats", 64'(bus.w_desc_o.num_beats), 64'd36);
            bus.aw_ready_i     = 1'b1;
            bus.w_desc_ready_i = 1'b1;
            cyc();
            bus.aw_ready_i     = 1'b0;
            bus.w_desc_ready_i = 1'b0;
            chk("bp done pulse", 64'(bus.xfer_done_o), 64'd1);
            chk("bp done aw_valid", 64'(bus.aw_valid_o), 64'd0);
            cyc();
            chk("bp after done", 64'(bus.xfer_done_o), 64'd0);
            chk("bp idle ready", 64'(bus.xfer_ready_o), 64'd1);
            chk("bp done count", 64'(done_cnt - d0), 64'd1);
        end

        begin
            int a0;
            a0 = aw_addr_q.size();
            start_xfer(48'h40, 16'd0, 1'b1);
            chk("zero done", 64'(bus.xfer_done_o), 64'd1);
            chk("zero aw_valid", 64'(bus.aw_valid_o), 64'd0);
            chk("zero w_valid", 64'(bus.w_desc_valid_o), 64'd0);
            cyc();
            chk("zero done end", 64'(bus.xfer_done_o), 64'd0);
            chk("zero ready", 64'(bus.xfer_ready_o), 64'd1);
            chk("zero no aw", 64'(aw_addr_q.size() - a0), 64'd0);
        end

        begin
            int d0;
            d0 = done_cnt;
            start_xfer(48'h0, 16'd10, 1'b1);
            cyc();
            chk("mrst issue aw_valid", 64'(bus.aw_valid_o), 64'd1);
            rst = 1'b1;
            cyc();
            chk("mrst aw_valid", 64'(bus.aw_valid_o), 64'd0);
            chk("mrst w_valid", 64'(bus.w_desc_valid_o), 64'd0);
            chk("mrst aw_len", 64'(bus.aw_len_o), 64'd0);
            chk("mrst w_desc", 64'(bus.w_desc_o), 64'd0);
            chk("mrst done", 64'(bus.xfer_done_o), 64'd0);
            rst = 1'b0;
            repeat (4) cyc();
            chk("mrst no done", 64'(done_cnt - d0), 64'd0);
            chk("mrst ready", 64'(bus.xfer_ready_o), 64'd1);
        end

        run_vec(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
